// File: rtl/mult_issue_sched_pkg.sv
// Shared types for the multiplier issue scheduler.
// Build option MULT_SCHED_RR_EN selects round-robin issue.
package mult_issue_sched_pkg;

  localparam int MULT_STAGES = 4;
  localparam int TAG_W       = 6;
  localparam int BMASK_W     = 4;

  typedef enum logic [1:0] {
    BR_NOP    = 2'd0,
    BR_CLEAR  = 2'd1,
    BR_SQUASH = 2'd2
  } br_task_e;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [BMASK_W-1:0] bmask;
  } shadow_t;

endpackage

// File: rtl/mult_issue_sched_arb.sv
// One-hot issue arbiter: round-robin with MULT_SCHED_RR_EN,
// lowest-index fixed priority otherwise.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
`ifdef MULT_SCHED_RR_EN
  input  logic               clock,
  input  logic               reset,
`endif
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant
);

`ifdef MULT_SCHED_RR_EN
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nx;
  logic          w_found;
  int            w_idx;

  always_comb begin
    o_grant  = '0;
    w_ptr_nx = r_ptr;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && i_en && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
        w_ptr_nx       = PW'((w_idx + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_ptr <= '0;
    else       r_ptr <= w_ptr_nx;
  end
`else
  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_en && i_req[k]) begin
        o_grant[k] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mult_issue_sched.sv
// Multiplier issue scheduler with shadow tag/bmask pipeline.
// Define MULT_SCHED_RR_EN for round-robin issue arbitration.
module mult_issue_sched
  import mult_issue_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MULT_STAGES = mult_issue_sched_pkg::MULT_STAGES,
  parameter int TAG_W       = mult_issue_sched_pkg::TAG_W,
  parameter int BMASK_W     = mult_issue_sched_pkg::BMASK_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ*BMASK_W-1:0] req_bmask,
  input  logic [1:0]                 rem_br_task,
  input  logic [BMASK_W-1:0]         rem_b_id,
  input  logic                       cdb_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       issue_valid,
  output logic                       mult_stall,
  output logic                       done_valid,
  output logic [TAG_W-1:0]           done_tag,
  output logic [BMASK_W-1:0]         done_bmask,
  output logic                       busy
);

  shadow_t            r_sh [MULT_STAGES];
  shadow_t            w_nx [MULT_STAGES];
  shadow_t            w_tail;
  shadow_t            w_new;
  logic               w_sq;
  logic               w_cl;
  logic               w_tail_live;
  logic [NUM_REQ-1:0] w_elig;

  assign w_sq   = br_task_e'(rem_br_task) == BR_SQUASH;
  assign w_cl   = br_task_e'(rem_br_task) == BR_CLEAR;
  assign w_tail = r_sh[MULT_STAGES-1];

  assign w_tail_live = w_tail.valid &&
                       !(w_sq && |(w_tail.bmask & rem_b_id));
  assign mult_stall  = w_tail_live && !cdb_grant;
  assign done_valid  = w_tail_live;
  assign done_tag    = w_tail.tag;
  assign done_bmask  = w_cl ? (w_tail.bmask & ~rem_b_id)
                            : w_tail.bmask;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_valid[i] &&
        !(w_sq && |(req_bmask[i*BMASK_W +: BMASK_W] & rem_b_id));
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef MULT_SCHED_RR_EN
    .clock   (clock),
    .reset   (reset),
`endif
    .i_req   (w_elig),
    .i_en    (!mult_stall),
    .o_grant (grant)
  );

  assign issue_valid = |grant;

  always_comb begin
    w_new       = '0;
    w_new.valid = issue_valid;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        w_new.tag   = w_new.tag | req_tag[i*TAG_W +: TAG_W];
        w_new.bmask = w_new.bmask | req_bmask[i*BMASK_W +: BMASK_W];
      end
    end
  end

  // Branch resolution applies to the post-shift contents.
  always_comb begin
    w_nx[0] = mult_stall ? r_sh[0] : w_new;
    for (int s = 1; s < MULT_STAGES; s++) begin
      w_nx[s] = mult_stall ? r_sh[s] : r_sh[s-1];
    end
    for (int s = 0; s < MULT_STAGES; s++) begin
      if (w_cl) w_nx[s].bmask = w_nx[s].bmask & ~rem_b_id;
      if (w_sq && |(w_nx[s].bmask & rem_b_id)) w_nx[s].valid = 1'b0;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < MULT_STAGES; s++) busy = busy | r_sh[s].valid;
  end

  always_ff @(posedge clock) begin
    for (int s = 0; s < MULT_STAGES; s++) begin
      if (reset) r_sh[s] <= '0;
      else       r_sh[s] <= w_nx[s];
    end
  end

endmodule
